// File: rtl/rv_lsu_apb_bridge_if.sv
// rv_lsu_apb_bridge_if
//   Bundles the LSU data-memory request/response signals and the APB4 master
//   signals of the LSU-to-APB bridge. Signal names keep their _i/_o suffixes
//   as seen from the bridge, so a waveform reads the same as the block's port list.
//
//   modport slave  : bridge view (accepts LSU requests, drives the APB bus)
//   modport master : environment view (LSU + APB slave side)
//
//   Handshake: the LSU raises data_req_i with stable attributes and holds it
//   until data_rvalid_o pulses for one cycle. It then drops the request in
//   that same cycle. On APB the bridge follows SETUP (psel) then ACCESS
//   (psel+penable) until pready_i, or until the watchdog expires.
interface rv_lsu_apb_bridge_if #(
  parameter int XLEN = 32
);
  logic              data_req_i;
  logic              data_we_i;
  logic [XLEN/8-1:0] data_be_i;
  logic [XLEN-1:0]   data_addr_i;
  logic [XLEN-1:0]   data_wdata_i;
  logic              data_rvalid_o;
  logic [XLEN-1:0]   data_rdata_o;
  logic              data_err_o;
  logic [XLEN-1:0]   paddr_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [XLEN-1:0]   pwdata_o;
  logic [XLEN/8-1:0] pstrb_o;
  logic [XLEN-1:0]   prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  prdata_i, pready_i, pslverr_i,
    output data_rvalid_o, data_rdata_o, data_err_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output prdata_i, pready_i, pslverr_i,
    input  data_rvalid_o, data_rdata_o, data_err_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/rv_lsu_apb_bridge.sv
// rv_lsu_apb_bridge
//   Converts LSU data-memory requests into single APB4 transfers, one at a
//   time. It has a watchdog against hung slaves and can suppress the response
//   when the LSU kills a request in flight.
//
//   Ports:
//     clk_i    core clock
//     arstn_i  asynchronous active-low reset
//     bus      rv_lsu_apb_bridge_if.slave (LSU request/response + APB4 master)
//     state_o  current FSM state (debug observation)
module rv_lsu_apb_bridge #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  rv_lsu_apb_bridge_if.slave    bus,
  output logic [1:0]            state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]        state_q,   state_d;
  logic [XLEN-1:0]   paddr_q,   paddr_d;
  logic              pwrite_q,  pwrite_d;
  logic [XLEN-1:0]   pwdata_q,  pwdata_d;
  logic [XLEN/8-1:0] pstrb_q,   pstrb_d;
  logic [XLEN-1:0]   rdata_q,   rdata_d;
  logic              err_q,     err_d;
  logic              abandon_q, abandon_d;
  logic [CW-1:0]     cnt_q,     cnt_d;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    abandon_d = abandon_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        abandon_d = 1'b0;
        cnt_d     = '0;
        if (bus.data_req_i) begin
          paddr_d  = {bus.data_addr_i[XLEN-1:2], 2'b00};
          pwrite_d = bus.data_we_i;
          pwdata_d = bus.data_wdata_i;
          // APB4 requires all strobes low on reads.
          pstrb_d  = bus.data_we_i ? bus.data_be_i : '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!bus.data_req_i) abandon_d = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // A kill cannot cancel the APB transfer. It only hides the response.
        if (!bus.data_req_i) abandon_d = 1'b1;
        if (bus.pready_i) begin
          rdata_d = pwrite_q ? '0 : bus.prdata_i;
          err_d   = bus.pslverr_i;
          state_d = S_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          // Hung slave: drop psel without pready so the LSU cannot deadlock.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      abandon_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      abandon_q <= abandon_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bus controls decode straight from registered state, so reset clears them at once.
  assign bus.psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable_o     = (state_q == S_ACCESS);
  assign bus.pwrite_o      = pwrite_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;
  assign bus.data_rvalid_o = (state_q == S_RESP) && !abandon_q;
  assign bus.data_err_o    = bus.data_rvalid_o && err_q;
  assign bus.data_rdata_o  = rdata_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_rv_lsu_apb_bridge.sv
// tb_rv_lsu_apb_bridge
//   Directed plus randomized bench for rv_lsu_apb_bridge. u_dut runs with a
//   4-cycle watchdog. u_dut0 has the watchdog disabled and is used only for
//   the wait-forever case. Inputs change on the falling edge. Outputs are
//   checked on the falling edge.
module tb_rv_lsu_apb_bridge;
  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic       clk_i = 1'b0;
  logic       arstn_i;
  logic [1:0] state, state0;

  always #5 clk_i = ~clk_i;

  rv_lsu_apb_bridge_if #(.XLEN(XLEN)) bus ();
  rv_lsu_apb_bridge_if #(.XLEN(XLEN)) bus0 ();

  rv_lsu_apb_bridge #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .bus(bus.slave), .state_o(state)
  );
  rv_lsu_apb_bridge #(.XLEN(XLEN), .TIMEOUT_CYCLES(0)) u_dut0 (
    .clk_i(clk_i), .arstn_i(arstn_i), .bus(bus0.slave), .state_o(state0)
  );

  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check for a quiet cycle: no transfer and no response, with the last rdata held.
  task automatic idle_check(input string tag);
    @(negedge clk_i);
    chk({tag, ".psel"},    32'(bus.psel_o), 32'd0);
    chk({tag, ".penable"}, 32'(bus.penable_o), 32'd0);
    chk({tag, ".rvalid"},  32'(bus.data_rvalid_o), 32'd0);
    chk({tag, ".err"},     32'(bus.data_err_o), 32'd0);
    chk({tag, ".rdata"},   bus.data_rdata_o, last_rdata);
  endtask

  // One LSU transaction, starting at a falling edge. pre = number of cycles
  // the bridge still needs before it is back in IDLE. waits = wait states
  // the slave inserts. kill < 0 means no kill. Otherwise the request drops
  // at phase (kill mod (phases+1)), where phase 0 is SETUP.
  // The task returns at the falling edge of the response cycle.
  task automatic xfer(input string tag, input logic [XLEN-1:0] addr, input logic we,
                      input logic [3:0] be, input logic [XLEN-1:0] wdata, input int waits,
                      input logic [XLEN-1:0] rdata, input logic slverr, input int kill,
                      input int pre, output bit abandoned);
    int              n_access, kill_ph;
    bit              timed_out;
    logic [XLEN-1:0] exp_addr, exp_rdata;
    logic [3:0]      exp_strb;
    logic            exp_err;
    timed_out = (TO != 0) && (waits >= TO);
    n_access  = timed_out ? TO : waits + 1;
    kill_ph   = (kill < 0) ? -1 : kill % (n_access + 1);
    abandoned = (kill_ph >= 0);
    exp_addr  = addr & ~32'h3;
    exp_strb  = we ? be : 4'h0;
    exp_rdata = timed_out ? '0 : (we ? '0 : rdata);
    exp_err   = timed_out ? 1'b1 : slverr;
    exp_q.push_back(exp_rdata);

    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = addr;
    bus.data_we_i    = we;
    bus.data_be_i    = be;
    bus.data_wdata_i = wdata;
    for (int p = 0; p < pre; p++) begin
      @(negedge clk_i);
      chk({tag, ".pre_psel"},   32'(bus.psel_o), 32'd0);
      chk({tag, ".pre_rvalid"}, 32'(bus.data_rvalid_o), 32'd0);
    end
    for (int ph = 0; ph <= n_access; ph++) begin
      @(negedge clk_i);
      chk({tag, ".psel"},    32'(bus.psel_o), 32'd1);
      chk({tag, ".penable"}, 32'(bus.penable_o), (ph != 0) ? 32'd1 : 32'd0);
      chk({tag, ".paddr"},   bus.paddr_o, exp_addr);
      chk({tag, ".pwrite"},  32'(bus.pwrite_o), 32'(we));
      chk({tag, ".pwdata"},  bus.pwdata_o, wdata);
      chk({tag, ".pstrb"},   32'(bus.pstrb_o), 32'(exp_strb));
      chk({tag, ".rvalid"},  32'(bus.data_rvalid_o), 32'd0);
      // Scramble LSU attributes after capture. The bridge must ignore them.
      bus.data_addr_i  = $urandom;
      bus.data_wdata_i = $urandom;
      bus.data_be_i    = 4'($urandom);
      bus.data_we_i    = 1'($urandom);
      if (ph >= 1) begin
        bus.pready_i  = ((ph - 1) >= waits);
        bus.prdata_i  = bus.pready_i ? rdata : $urandom;
        bus.pslverr_i = bus.pready_i ? slverr : 1'($urandom);
      end
      if (ph == kill_ph) bus.data_req_i = 1'b0;
    end
    @(negedge clk_i);
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    last_rdata    = exp_q.pop_front();
    chk({tag, ".resp_psel"},    32'(bus.psel_o), 32'd0);
    chk({tag, ".resp_penable"}, 32'(bus.penable_o), 32'd0);
    chk({tag, ".rvalid"},       32'(bus.data_rvalid_o), abandoned ? 32'd0 : 32'd1);
    chk({tag, ".err"},          32'(bus.data_err_o), abandoned ? 32'd0 : 32'(exp_err));
    chk({tag, ".rdata"},        bus.data_rdata_o, last_rdata);
    // The LSU drops its request while rvalid is high.
    if (!abandoned) bus.data_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              ab;
    logic [XLEN-1:0] a, w, r;
    logic            we, se;
    logic [3:0]      be;
    int              waits, kill, pre;

    bus.data_req_i = 0; bus.data_we_i = 0; bus.data_be_i = 0; bus.data_addr_i = 0;
    bus.data_wdata_i = 0; bus.prdata_i = 0; bus.pready_i = 0; bus.pslverr_i = 0;
    bus0.data_req_i = 0; bus0.data_we_i = 0; bus0.data_be_i = 0; bus0.data_addr_i = 0;
    bus0.data_wdata_i = 0; bus0.prdata_i = 0; bus0.pready_i = 0; bus0.pslverr_i = 0;
    arstn_i = 1'b0;

    // Reset values
    #1;
    chk("rst.psel",   32'(bus.psel_o), 32'd0);
    chk("rst.pen",    32'(bus.penable_o), 32'd0);
    chk("rst.pwrite", 32'(bus.pwrite_o), 32'd0);
    chk("rst.paddr",  bus.paddr_o, 32'd0);
    chk("rst.pwdata", bus.pwdata_o, 32'd0);
    chk("rst.pstrb",  32'(bus.pstrb_o), 32'd0);
    chk("rst.rdata",  bus.data_rdata_o, 32'd0);
    chk("rst.rvalid", 32'(bus.data_rvalid_o), 32'd0);
    chk("rst.err",    32'(bus.data_err_o), 32'd0);
    @(negedge clk_i);
    arstn_i = 1'b1;
    idle_check("rst.idle");

    // Zero-wait load with an unaligned address
    xfer("load0", 32'h1000_0006, 1'b0, 4'hF, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0, -1, 0, ab);
    idle_check("load0.after");

    // Store with two wait states
    xfer("store2", 32'h0000_0020, 1'b1, 4'b1100, 32'hAB00_0000, 2, 32'h5555_AAAA, 1'b0, -1, 0, ab);
    idle_check("store2.after");

    // Slave error on a load
    xfer("slverr", 32'h0000_0104, 1'b0, 4'hF, 32'h0, 1, 32'hCAFE_F00D, 1'b1, -1, 0, ab);
    idle_check("slverr.after");

    // Watchdog: the slave never answers, so ACCESS lasts exactly TO cycles
    xfer("tmo", 32'h0000_0200, 1'b0, 4'hF, 32'h0, 100, 32'h1111_1111, 1'b0, -1, 0, ab);
    idle_check("tmo.after");

    // Watchdog disabled: the bridge keeps waiting, then a late kill hides the response
    bus0.data_req_i  = 1'b1;
    bus0.data_addr_i = 32'h0000_0303;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk_i);
      chk("to0.psel", 32'(bus0.psel_o), 32'd1);
      chk("to0.pen",  32'(bus0.penable_o), (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("to0.paddr", bus0.paddr_o, 32'h0000_0300);
    bus0.data_req_i = 1'b0;
    bus0.pready_i   = 1'b1;
    bus0.prdata_i   = 32'h7777_0000;
    @(negedge clk_i);
    bus0.pready_i = 1'b0;
    chk("to0.resp_psel", 32'(bus0.psel_o), 32'd0);
    chk("to0.rvalid",    32'(bus0.data_rvalid_o), 32'd0);
    chk("to0.err",       32'(bus0.data_err_o), 32'd0);
    chk("to0.rdata",     bus0.data_rdata_o, 32'h7777_0000);
    @(negedge clk_i);
    chk("to0.idle_psel", 32'(bus0.psel_o), 32'd0);
    chk("to0.idle_rv",   32'(bus0.data_rvalid_o), 32'd0);

    // Abandon during ACCESS, then a request held through RESP runs back-to-back
    xfer("abandon", 32'h0000_0040, 1'b0, 4'hF, 32'h0, 3, 32'h0BAD_0BAD, 1'b0, 2, 0, ab);
    xfer("b2b", 32'h0000_0044, 1'b0, 4'hF, 32'h0, 0, 32'h600D_600D, 1'b0, -1, 1, ab);
    idle_check("b2b.after");

    // Reset in the middle of ACCESS
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h0000_0500;
    bus.data_we_i   = 1'b1;
    bus.data_be_i   = 4'hF;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mrst.in_access", 32'(bus.penable_o), 32'd1);
    #2 arstn_i = 1'b0;
    #1;
    chk("mrst.psel",   32'(bus.psel_o), 32'd0);
    chk("mrst.pen",    32'(bus.penable_o), 32'd0);
    chk("mrst.rvalid", 32'(bus.data_rvalid_o), 32'd0);
    chk("mrst.paddr",  bus.paddr_o, 32'd0);
    chk("mrst.pstrb",  32'(bus.pstrb_o), 32'd0);
    chk("mrst.rdata",  bus.data_rdata_o, 32'd0);
    bus.data_req_i = 1'b0;
    last_rdata     = '0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("mrst.idle");

    // Randomized transfers: waits past TO exercise the watchdog, and some are killed
    pre = 0;
    for (int n = 0; n < 40; n++) begin
      a     = $urandom;
      w     = $urandom;
      r     = $urandom;
      we    = 1'($urandom);
      se    = ($urandom_range(0, 5) == 0);
      be    = 4'($urandom);
      waits = $urandom_range(0, 6);
      kill  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      xfer("rnd", a, we, be, w, waits, r, se, kill, pre, ab);
      if (ab) begin
        pre = 1;
      end else begin
        pre = 0;
        repeat ($urandom_range(1, 2)) idle_check("rnd.idle");
      end
    end
    if (pre != 0) begin
      bus.data_req_i = 1'b0;
      idle_check("rnd.tail");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_lsu_apb_bridge.md
Name: rv_lsu_apb_bridge

Overview:
Converts the LSU data-memory request/response interface into an AMBA APB4 master. The LSU holds the request and the bridge returns a single-cycle response pulse. The block sits directly downstream of the load/store unit, between it and the data-side peripheral bus. It runs one APB transfer at a time, adds a watchdog timeout against hung slaves, and reports slave or timeout errors alongside the response.

Parameters:
XLEN, 32, data/address width (only 32 is supported)
TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles with pready low before the transfer is aborted; 0 disables the timeout

Ports:
clk_i  input  1  core clock
arstn_i  input  1  asynchronous active-low reset
data_req_i  input  1  LSU request; held high until data_rvalid_o
data_we_i  input  1  1 = store, 0 = load
data_be_i  input  XLEN/8  byte enables, already lane-aligned
data_addr_i  input  XLEN  byte address
data_wdata_i  input  XLEN  store data, already lane-rotated
data_rvalid_o  output  1  one-cycle response pulse
data_rdata_o  output  XLEN  load data; valid when data_rvalid_o=1
data_err_o  output  1  error flag; valid when data_rvalid_o=1
paddr_o  output  XLEN  APB address, word-aligned
psel_o  output  1  APB select
penable_o  output  1  APB enable
pwrite_o  output  1  APB write
pwdata_o  output  XLEN  APB write data
pstrb_o  output  XLEN/8  APB write strobes
prdata_i  input  XLEN  APB read data
pready_i  input  1  APB ready
pslverr_i  input  1  APB slave error

Behaviour:
- Clock and reset: one clock, clk_i. Reset arstn_i is asynchronous, active-low.
- Reset values: state=IDLE; psel_o=penable_o=pwrite_o=0; paddr_o, pwdata_o, pstrb_o, data_rdata_o = 0; data_rvalid_o=data_err_o=0; timeout counter=0; abandon flag=0.
- Reset asserted mid-transfer: all outputs return to reset values immediately. No response is produced.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If data_req_i=1, register the following and go to SETUP:
    - paddr_o = {data_addr_i[XLEN-1:2], 2'b00}
    - pwrite_o = data_we_i
    - pwdata_o = data_wdata_i
    - pstrb_o = data_we_i ? data_be_i : 0 (APB4: strobes are zero on reads)
  - Clear the abandon flag and the timeout counter.
- SETUP: psel_o=1, penable_o=0. Always goes to ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - If pready_i=1: capture the result and go to RESP.
    - data_rdata_o = pwrite_o ? 0 : prdata_i
    - data_err_o = pslverr_i
  - Else, if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: abort and go to RESP.
    - data_rdata_o = 0, data_err_o = 1
    - psel_o and penable_o drop next cycle (deliberate APB violation for hung slaves).
  - Else: counter increments.
- RESP:
  - psel_o=penable_o=0.
  - data_rvalid_o=1 for exactly this cycle, unless the abandon flag is set (then 0).
  - data_err_o is forced to 0 whenever data_rvalid_o=0.
  - Always goes to IDLE.
- Address/control registers hold while psel_o=1 and do not track LSU inputs after capture.
- data_rdata_o holds its last captured value outside RESP.
- Abandon: if data_req_i=0 in any SETUP or ACCESS cycle (upstream kill), set the abandon flag. The APB transfer still completes (APB cannot be cancelled), then the response is suppressed.
- Requests arriving while not in IDLE are ignored until IDLE. The LSU keeps data_req_i high, so the request is accepted there.
- Minimum latency: request seen in IDLE at cycle T, SETUP at T+1, ACCESS at T+2 (zero-wait slave), data_rvalid_o at T+3. Each slave wait state adds one cycle.
- Throughput: one transfer per 4 cycles minimum. IDLE is always visited between transfers.
- Response cycle: the LSU drops its request combinationally while data_rvalid_o=1. The bridge does not sample data_req_i in RESP.

Test Plan:
- Reset: assert arstn_i mid-ACCESS -> psel_o/penable_o/data_rvalid_o go 0 asynchronously; after release, state IDLE, no response pulse.
- Zero-wait load: req at T0, addr=0x1000_0006, we=0, prdata=0xDEAD_BEEF -> paddr_o=0x1000_0004, pstrb_o=0, psel_o at T1, penable_o at T2, data_rvalid_o=1 at T3 only, rdata=0xDEAD_BEEF, err=0.
- Store with 2 wait states: addr=0x20, be=4'b1100, wdata=0xAB00_0000 -> pwrite_o=1, pstrb_o=4'b1100, pwdata_o stable; ACCESS lasts 3 cycles; rvalid at T5, rdata=0, err=0.
- Slave error: pslverr_i=1 with pready_i=1 on a load -> rvalid=1, err=1 in the same cycle; err=0 the next cycle.
- Timeout: TIMEOUT_CYCLES=4, pready_i held 0 -> ACCESS lasts exactly 4 cycles, then psel_o=0 and rvalid=1 with err=1, rdata=0; with TIMEOUT_CYCLES=0 the bridge waits indefinitely.
- Abandon and back-to-back: drop data_req_i during ACCESS (pready after 3 waits) -> APB completes, no rvalid; a new req held in RESP is accepted in the following IDLE, and its response arrives 3 cycles after acceptance.
